// File: rtl/mem_access_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and the big-endian load extraction used by both the unit and the writeback mux.
package mem_access_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STORE,
        RMW_RD,
        RMW_WR,
        FAULT
    } mem_state_t;

    // The addressed byte sits in the top lane because the RAM is big-endian.
    function automatic logic [31:0] extend_load(input logic [2:0] funct3,
                                                input logic [31:0] word);
        logic [31:0] result;
        case (funct3)
            F3_B:    result = {{24{word[31]}}, word[31:24]};
            F3_H:    result = {{16{word[31]}}, word[31:16]};
            F3_BU:   result = {24'd0, word[31:24]};
            F3_HU:   result = {16'd0, word[31:16]};
            default: result = word;
        endcase
        return result;
    endfunction

    function automatic logic legal_funct3(input logic isWrite,
                                          input logic [2:0] funct3);
        logic ok;
        if (isWrite) begin
            ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        end else begin
            ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                 (funct3 == F3_BU) || (funct3 == F3_HU);
        end
        return ok;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load extraction: raw RAM word plus funct3 gives the
// sign/zero-extended register value.
module mem_load_align
    import mem_access_pkg::*;
#(
    parameter int dataW = 32
) (
    input  logic [2:0]       funct3,
    input  logic [dataW-1:0] ram_out,
    output logic [dataW-1:0] load_data
);

    assign load_data = extend_load(funct3, ram_out);

endmodule

// File: rtl/mem_access_unit.sv
// Initiator side of the zero-delay big-endian RAM: executes RV32I loads and
// stores, using read-modify-write for sub-word stores.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int dataW       = 32,
    parameter int RAMAddrSize = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [2:0]             req_funct3,
    input  logic [31:0]            req_addr,
    input  logic [dataW-1:0]       req_wdata,
    output logic                   resp_valid,
    output logic [dataW-1:0]       resp_rdata,
    output logic                   resp_fault,
    output logic [RAMAddrSize-1:0] RAMAddr,
    output logic [dataW-1:0]       DataIn,
    output logic                   RAMWriteControl,
    input  logic [dataW-1:0]       RAMOut
);

    // Highest start address whose 4-byte window still fits in the RAM.
    localparam logic [31:0] maxAddr = 32'((64'd1 << RAMAddrSize) - 64'd4);

    mem_state_t state_q, state_d;

    logic [RAMAddrSize-1:0] addr_q;
    logic [RAMAddrSize-1:0] lastAddr_q;
    logic [2:0]             funct3_q;
    logic [dataW-1:0]       wdata_q;
    logic [dataW-1:0]       merge_q;
    logic [dataW-1:0]       mergeWord;
    logic [dataW-1:0]       loadData;
    logic                   accept;
    logic                   reqFault;
    logic                   respValid_d;
    logic                   respFault_d;
    logic [dataW-1:0]       respRdata_d;
    logic                   accessState;

    mem_load_align #(
        .dataW(dataW)
    ) u_load_align (
        .funct3   (funct3_q),
        .ram_out  (RAMOut),
        .load_data(loadData)
    );

    assign accept      = req_valid && (state_q == IDLE);
    assign reqFault    = (req_addr > maxAddr) || !legal_funct3(req_write, req_funct3);
    assign accessState = (state_q == LOAD) || (state_q == STORE) ||
                         (state_q == RMW_RD) || (state_q == RMW_WR);

    // Only the top byte/half is replaced; the rest of the window is written back as read.
    assign mergeWord = (funct3_q == F3_B) ? {wdata_q[7:0], RAMOut[dataW-9:0]}
                                          : {wdata_q[15:0], RAMOut[dataW-17:0]};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // RAM strobes are decoded from state so a reset kills a write in the same instant.
    always_comb begin
        state_d         = state_q;
        req_ready       = 1'b0;
        RAMAddr         = lastAddr_q;
        DataIn          = '0;
        RAMWriteControl = 1'b0;
        respValid_d     = 1'b0;
        respRdata_d     = '0;
        respFault_d     = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (reqFault) begin
                        state_d = FAULT;
                    end else if (!req_write) begin
                        state_d = LOAD;
                    end else if (req_funct3 == F3_W) begin
                        state_d = STORE;
                    end else begin
                        state_d = RMW_RD;
                    end
                end
            end
            LOAD: begin
                RAMAddr     = addr_q;
                respValid_d = 1'b1;
                respRdata_d = loadData;
                state_d     = IDLE;
            end
            STORE: begin
                RAMAddr         = addr_q;
                DataIn          = wdata_q;
                RAMWriteControl = 1'b1;
                respValid_d     = 1'b1;
                state_d         = IDLE;
            end
            RMW_RD: begin
                RAMAddr = addr_q;
                state_d = RMW_WR;
            end
            RMW_WR: begin
                RAMAddr         = addr_q;
                DataIn          = merge_q;
                RAMWriteControl = 1'b1;
                respValid_d     = 1'b1;
                state_d         = IDLE;
            end
            FAULT: begin
                respValid_d = 1'b1;
                respFault_d = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q     <= '0;
            funct3_q   <= '0;
            wdata_q    <= '0;
            merge_q    <= '0;
            lastAddr_q <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_fault <= 1'b0;
        end else begin
            if (accept) begin
                addr_q   <= req_addr[RAMAddrSize-1:0];
                funct3_q <= req_funct3;
                wdata_q  <= req_wdata;
            end
            if (state_q == RMW_RD) begin
                merge_q <= mergeWord;
            end
            if (accessState) begin
                lastAddr_q <= addr_q;
            end
            resp_valid <= respValid_d;
            resp_rdata <= respRdata_d;
            resp_fault <= respFault_d;
        end
    end

endmodule
